// File: rtl/exers.sv
// exers: integer execute reservation station; captures operands from writeback
// and issues the lowest-index ready op each cycle to the integer unit.
module exers #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rename_exers_write,
    input  logic [4:0]  rename_op,
    input  logic [7:0]  rename_robid,
    input  logic [5:0]  rename_rd,
    input  logic        rename_op1ready,
    input  logic [31:0] rename_op1,
    input  logic        rename_op2ready,
    input  logic [31:0] rename_op2,
    input  logic [31:0] rename_imm,
    output logic        exers_stall,
    input  logic        wb_valid,
    input  logic [7:0]  wb_robid,
    input  logic [31:0] wb_result,
    output logic        exers_issue_valid,
    output logic [4:0]  exers_issue_op,
    output logic [7:0]  exers_issue_robid,
    output logic [5:0]  exers_issue_rd,
    output logic [31:0] exers_issue_op1,
    output logic [31:0] exers_issue_op2,
    output logic [31:0] exers_issue_imm,
    input  logic        eu_stall,
    input  logic        rob_flush
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
    logic [4:0]       op_q [DEPTH];
    logic [4:0]       op_d [DEPTH];
    logic [7:0]       robid_q [DEPTH];
    logic [7:0]       robid_d [DEPTH];
    logic [5:0]       rd_q [DEPTH];
    logic [5:0]       rd_d [DEPTH];
    logic [31:0]      v1_q [DEPTH];
    logic [31:0]      v1_d [DEPTH];
    logic [31:0]      v2_q [DEPTH];
    logic [31:0]      v2_d [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [31:0]      imm_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             iv_q, iv_d;
    logic [4:0]       iop_q, iop_d;
    logic [7:0]       irob_q, irob_d;
    logic [5:0]       ird_q, ird_d;
    logic [31:0]      iop1_q, iop1_d, iop2_q, iop2_d, iimm_q, iimm_d;
    logic [IW-1:0]    wsel, isel;
    logic             ifound, we, fire, iss, byp1, byp2;

    always_comb begin
        wsel = '0;
        isel = '0;
        ifound = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) wsel = IW'(i);
            if (valid_q[i] && r1_q[i] && r2_q[i]) begin
                ifound = 1'b1;
                isel = IW'(i);
            end
        end
    end

    assign we   = rename_exers_write && (count_q < CW'(DEPTH));
    assign fire = !iv_q || !eu_stall;
    assign iss  = fire && ifound;
    assign byp1 = !rename_op1ready && wb_valid && (rename_op1[7:0] == wb_robid);
    assign byp2 = !rename_op2ready && wb_valid && (rename_op2[7:0] == wb_robid);

    always_comb begin
        valid_d = valid_q;
        r1_d = r1_q;
        r2_d = r2_q;
        op_d = op_q;
        robid_d = robid_q;
        rd_d = rd_q;
        v1_d = v1_q;
        v2_d = v2_q;
        imm_d = imm_q;
        count_d = count_q + CW'(we) - CW'(iss);
        iv_d = iv_q;
        iop_d = iop_q;
        irob_d = irob_q;
        ird_d = ird_q;
        iop1_d = iop1_q;
        iop2_d = iop2_q;
        iimm_d = iimm_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && valid_q[i] && !r1_q[i] && v1_q[i][7:0] == wb_robid) begin
                r1_d[i] = 1'b1;
                v1_d[i] = wb_result;
            end
            if (wb_valid && valid_q[i] && !r2_q[i] && v2_q[i][7:0] == wb_robid) begin
                r2_d[i] = 1'b1;
                v2_d[i] = wb_result;
            end
        end
        if (iss) valid_d[isel] = 1'b0;
        if (we) begin
            valid_d[wsel] = 1'b1;
            op_d[wsel] = rename_op;
            robid_d[wsel] = rename_robid;
            rd_d[wsel] = rename_rd;
            imm_d[wsel] = rename_imm;
            r1_d[wsel] = rename_op1ready || byp1;
            v1_d[wsel] = byp1 ? wb_result : rename_op1;
            r2_d[wsel] = rename_op2ready || byp2;
            v2_d[wsel] = byp2 ? wb_result : rename_op2;
        end
        if (fire) begin
            iv_d = ifound;
            if (ifound) begin
                iop_d = op_q[isel];
                irob_d = robid_q[isel];
                ird_d = rd_q[isel];
                iop1_d = v1_q[isel];
                iop2_d = v2_q[isel];
                iimm_d = imm_q[isel];
            end
        end
        if (rob_flush) begin
            valid_d = '0;
            count_d = '0;
            iv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            iv_q <= 1'b0;
            iop_q <= '0;
            irob_q <= '0;
            ird_q <= '0;
            iop1_q <= '0;
            iop2_q <= '0;
            iimm_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            iv_q <= iv_d;
            iop_q <= iop_d;
            irob_q <= irob_d;
            ird_q <= ird_d;
            iop1_q <= iop1_d;
            iop2_q <= iop2_d;
            iimm_q <= iimm_d;
        end
    end

    // Entry payloads are qualified by valid_q and need no reset.
    always_ff @(posedge clk) begin
        r1_q <= r1_d;
        r2_q <= r2_d;
        op_q <= op_d;
        robid_q <= robid_d;
        rd_q <= rd_d;
        v1_q <= v1_d;
        v2_q <= v2_d;
        imm_q <= imm_d;
    end

    assign exers_stall       = count_q >= CW'(DEPTH - 1);
    assign exers_issue_valid = iv_q;
    assign exers_issue_op    = iop_q;
    assign exers_issue_robid = irob_q;
    assign exers_issue_rd    = ird_q;
    assign exers_issue_op1   = iop1_q;
    assign exers_issue_op2   = iop2_q;
    assign exers_issue_imm   = iimm_q;
endmodule

// File: doc/exers.md
# exers

Integer execute reservation station. Accepts dispatched ops from the rename stage over the `rename_exers_*` interface and holds them until both operands are available. Captures missing operands from the writeback broadcast, then issues one ready op per cycle to the integer execution unit. Throttles rename through `exers_stall`. Sits between rename and the ALU/branch unit.

## Interface
Parameters:
- `DEPTH`, 8: number of entries, a power of 2 and at least 4.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rename_exers_write`, in, 1: dispatch write strobe.
- `rename_op`, in, 5: execution op code.
- `rename_robid`, in, 8: ROB id of the op.
- `rename_rd`, in, 6: destination register.
- `rename_op1ready`, in, 1: 1 means `rename_op1` is a value; 0 means `rename_op1[7:0]` is the producer robid tag.
- `rename_op1`, in, 32: operand 1 value or tag.
- `rename_op2ready`, in, 1: same meaning as `rename_op1ready`, for operand 2.
- `rename_op2`, in, 32: operand 2 value or tag.
- `rename_imm`, in, 32: immediate, passed through to issue.
- `exers_stall`, out, 1: back-pressure to rename.
- `wb_valid`, in, 1: result broadcast valid.
- `wb_robid`, in, 8: tag of the broadcast result.
- `wb_result`, in, 32: broadcast result value.
- `exers_issue_valid`, out, 1: issue register holds an op.
- `exers_issue_op`, out, 5: op code of the issued op.
- `exers_issue_robid`, out, 8: ROB id of the issued op.
- `exers_issue_rd`, out, 6: destination register of the issued op.
- `exers_issue_op1`, out, 32: operand 1 value.
- `exers_issue_op2`, out, 32: operand 2 value.
- `exers_issue_imm`, out, 32: immediate.
- `eu_stall`, in, 1: execution unit cannot accept; hold the issue register.
- `rob_flush`, in, 1: squash all speculative state.

## Operation
- Entry fields: `valid`, `op`, `robid`, `rd`, `r1`, `v1[31:0]`, `r2`, `v2[31:0]`, `imm`. `count` tracks the number of valid entries (width $clog2(DEPTH)+1).
- **Write**
  - When `rename_exers_write` is 1 and `count < DEPTH`, load the lowest-index free entry.
  - When the station is full, the write is dropped. This is a protocol violation; the bench flags it as an error.
- **Write bypass**
  - If `wb_valid` is 1 in the same cycle and an incoming operand is not ready with tag equal to `wb_robid`, store `wb_result` with ready=1.
  - Each operand is checked independently.
- **Wakeup**
  - Every cycle with `wb_valid`=1, every valid entry whose operand has ready=0 and `v[7:0] == wb_robid` stores `wb_result` and sets ready=1.
  - Both operands of one entry may wake in the same cycle.
- **Select**
  - Candidates are valid entries with r1 & r2 = 1, using registered state only. Ops written or woken in the current cycle are not candidates until the next cycle.
  - Pick the lowest-index candidate.
  - Selection fires when `!exers_issue_valid || !eu_stall`.
- **Issue**
  - When selection fires with a candidate: copy the entry into the issue register, set `exers_issue_valid`=1, and clear the entry's `valid`.
  - When selection fires with no candidate: `exers_issue_valid` becomes 0.
  - When `eu_stall`=1 and `exers_issue_valid`=1: the issue register holds unchanged.
- **Count**
  - +1 on an accepted write, −1 on issue.
  - A write and an issue in the same cycle leave `count` unchanged.
- **Stall**: `exers_stall = (count >= DEPTH-1)`, combinational from registered `count`. This reserves one slot for the op already latched in rename.
- **Flush and reset**
  - `rob_flush` or `rst`: all entry `valid` = 0, `count` = 0, `exers_issue_valid` = 0.
  - A write or wakeup presented in the same cycle is discarded.
  - `rst` takes priority over everything.

## Timing
- Reset values:
  - `exers_issue_valid`=0 and `exers_stall`=0.
  - Issue data outputs are 0.
  - Entry payloads are don't-care.
- Minimum latency: a write at edge E with both operands ready gives `exers_issue_valid`=1 after edge E+1.
- A wakeup at edge E (including a write bypass) makes the op issuable at edge E+1.
- Throughput: one issue per cycle while `eu_stall`=0.
- `exers_stall` changes only after a clock edge. It has no combinational path from any input.
- Wakeup does not forward to the issue register. An entry in the issue register already holds values.

## Test plan
- Reset, then write op=3, robid=5, op1=10 (ready), op2=20 (ready) -> next cycle `exers_issue_valid`=1, op1=10, op2=20, robid=5.
- Write robid=7 with op1 not ready (tag 0x04) -> no issue. Then `wb_valid`, `wb_robid`=4, `wb_result`=0xDEAD -> issue one cycle later with op1=0xDEAD.
- Write in the same cycle as the matching wakeup (tag 9, result 0x55) -> entry captures 0x55 and issues the next cycle.
- Fill to 7 entries with unready ops -> `exers_stall`=1. Wake one, let it issue -> `count`=6 and `exers_stall`=0.
- Two ready entries with `eu_stall`=1 -> issue register holds the index-0 op for 3 cycles. Release -> index-1 op issues the next cycle.
- `rob_flush` with 5 entries and a valid issue register -> next cycle `exers_issue_valid`=0, `count`=0, and a subsequent write issues normally.
